multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 57 +++++
 rtl/ctrl_decode.sv | 51 +++++
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, immediate-generator
// selects, write-back selects, FSM state and instruction-class encodings.
package multicycle_ctrl_pkg;

  localparam logic [2:0] EXTOP_I = 3'b000;
  localparam logic [2:0] EXTOP_U = 3'b001;
  localparam logic [2:0] EXTOP_S = 3'b010;
  localparam logic [2:0] EXTOP_B = 3'b011;
  localparam logic [2:0] EXTOP_J = 3'b100;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_IALU    = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } inst_class_t;

  function automatic logic [1:0] wb_sel_of(input inst_class_t cls);
    case (cls)
      CLS_LOAD:          return WB_MEM;
      CLS_JAL, CLS_JALR: return WB_PC4;
      default:           return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: maps IR[6:0] to instruction class,
// immediate-generator select, ALU operand-B source and legality.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]  i_opcode,
  output inst_class_t o_cls,
  output logic [2:0]  o_extop,
  output logic        o_alu_bsrc,
  output logic        o_legal
);

  always_comb begin
    o_cls      = CLS_ILLEGAL;
    o_extop    = EXTOP_I;
    o_alu_bsrc = 1'b1;
    o_legal    = 1'b1;
    case (i_opcode)
      OPC_R: begin
        o_cls      = CLS_R;
        o_alu_bsrc = 1'b0;
      end
      OPC_IALU:   o_cls = CLS_IALU;
      OPC_LOAD:   o_cls = CLS_LOAD;
      OPC_JALR:   o_cls = CLS_JALR;
      OPC_STORE: begin
        o_cls   = CLS_STORE;
        o_extop = EXTOP_S;
      end
      OPC_BRANCH: begin
        o_cls      = CLS_BRANCH;
        o_extop    = EXTOP_B;
        o_alu_bsrc = 1'b0;
      end
      OPC_JAL: begin
        o_cls   = CLS_JAL;
        o_extop = EXTOP_J;
      end
      OPC_LUI: begin
        o_cls   = CLS_LUI;
        o_extop = EXTOP_U;
      end
      OPC_AUIPC: begin
        o_cls   = CLS_AUIPC;
        o_extop = EXTOP_U;
      end
      default:    o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with instruction register and sticky trap.
// Define MC_CTRL_PERF_EN to build the cycle / retired-instruction counters.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        branch_taken,
  output logic [31:0] inst,
  output logic [2:0]  extop,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_bsrc,
  output logic        illegal,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instret
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_inst;
  logic        r_illegal;

  inst_class_t w_cls;
  logic        w_legal;
  logic        w_ir_load;
  logic        w_imem_req;
  logic        w_dmem_req;
  logic        w_dmem_we;
  logic        w_pc_we;
  logic        w_pc_sel;
  logic        w_reg_we;

  ctrl_decode u_decode (
    .i_opcode   (r_inst[6:0]),
    .o_cls      (w_cls),
    .o_extop    (extop),
    .o_alu_bsrc (alu_bsrc),
    .o_legal    (w_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_inst    <= NOP_INST;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_ir_load)
        r_inst <= imem_rdata;
      if (r_state == ST_DECODE && !w_legal)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ir_load    = 1'b0;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_sel     = 1'b0;
    w_reg_we     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) begin
          w_ir_load    = 1'b1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_state_next = w_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        if (w_cls == CLS_LOAD || w_cls == CLS_STORE) begin
          w_state_next = ST_MEM;
        end else if (w_cls == CLS_BRANCH) begin
          w_pc_we      = 1'b1;
          w_pc_sel     = branch_taken;
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_WB;
        end
      end
      ST_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (w_cls == CLS_STORE);
        if (dmem_ready) begin
          // Stores retire here; loads still need the write-back cycle.
          if (w_cls == CLS_STORE) begin
            w_pc_we      = 1'b1;
            w_state_next = ST_FETCH;
          end else begin
            w_state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        w_reg_we     = 1'b1;
        w_pc_we      = 1'b1;
        w_pc_sel     = (w_cls == CLS_JAL || w_cls == CLS_JALR);
        w_state_next = ST_FETCH;
      end
      default: begin
        w_state_next = ST_TRAP;
      end
    endcase
  end

  // Reset parks the FSM in FETCH; masking keeps every request low until release.
  assign imem_req = w_imem_req & ~rst;
  assign dmem_req = w_dmem_req & ~rst;
  assign dmem_we  = w_dmem_we  & ~rst;
  assign pc_we    = w_pc_we    & ~rst;
  assign pc_sel   = w_pc_sel   & ~rst;
  assign reg_we   = w_reg_we   & ~rst;
  assign inst     = r_inst;
  assign wb_sel   = wb_sel_of(w_cls);
  assign illegal  = r_illegal;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cycles  <= 32'd0;
      r_perf_instret <= 32'd0;
    end else if (r_state != ST_TRAP) begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_pc_we)
        r_perf_instret <= r_perf_instret + 32'd1;
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_instret = r_perf_instret;
`else
  assign perf_cycles  = 32'd0;
  assign perf_instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; counter expectations
// follow MC_CTRL_PERF_EN.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic        dmem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic        branch_taken;
  logic [31:0] inst;
  logic [2:0]  extop;
  logic        pc_we;
  logic        pc_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        alu_bsrc;
  logic        illegal;
  logic [31:0] perf_cycles;
  logic [31:0] perf_instret;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LW   = 32'h0000_A103;
  localparam logic [31:0] BEQ  = 32'h0000_0463;
  localparam logic [31:0] SW   = 32'h0011_2023;
  localparam logic [31:0] JAL  = 32'h0080_006F;
  localparam logic [31:0] BAD  = 32'h0000_007F;
  localparam logic [31:0] NOP  = 32'h0000_0013;

`ifdef MC_CTRL_PERF_EN
  localparam logic [31:0] EXP_INSTRET = 32'd10;
  localparam logic [31:0] EXP_CYC40   = 32'd40;
  localparam logic [31:0] EXP_CYC42   = 32'd42;
`else
  localparam logic [31:0] EXP_INSTRET = 32'd0;
  localparam logic [31:0] EXP_CYC40   = 32'd0;
  localparam logic [31:0] EXP_CYC42   = 32'd0;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .dmem_ready   (dmem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .branch_taken (branch_taken),
    .inst         (inst),
    .extop        (extop),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .alu_bsrc     (alu_bsrc),
    .illegal      (illegal),
    .perf_cycles  (perf_cycles),
    .perf_instret (perf_instret)
  );

  // Strobe vector order: {imem_req, dmem_req, dmem_we, pc_we, pc_sel, reg_we}
  logic [5:0] strobes;
  assign strobes = {imem_req, dmem_req, dmem_we, pc_we, pc_sel, reg_we};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check the strobes.
  task automatic cyc(input string tag, input logic irdy, input logic [31:0] idata,
                     input logic drdy, input logic br, input logic [5:0] exp);
    @(negedge clk);
    imem_ready   = irdy;
    imem_rdata   = idata;
    dmem_ready   = drdy;
    branch_taken = br;
    #1;
    check(tag, {26'd0, strobes}, {26'd0, exp});
  endtask

  task automatic run_addi(input int idx);
    cyc($sformatf("addi%0d_fetch", idx), 1'b1, ADDI, 1'b0, 1'b0, 6'b100000);
    cyc($sformatf("addi%0d_dec", idx),   1'b0, NOP,  1'b0, 1'b0, 6'b000000);
    cyc($sformatf("addi%0d_exec", idx),  1'b0, NOP,  1'b0, 1'b0, 6'b000000);
    cyc($sformatf("addi%0d_wb", idx),    1'b0, NOP,  1'b0, 1'b0, 6'b000101);
  endtask

  initial begin
    rst = 1'b1; imem_rdata = NOP; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_strobes", {26'd0, strobes}, 32'd0);
    check("rst_ir", inst, NOP);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_cycles", perf_cycles, 32'd0);
    check("rst_instret", perf_instret, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // ADDI with stray imem_ready/illegal data after FETCH, which must be ignored
    cyc("addi_fetch", 1'b1, ADDI, 1'b0, 1'b0, 6'b100000);
    cyc("addi_dec",   1'b1, BAD,  1'b1, 1'b0, 6'b000000);
    check("addi_ir", inst, ADDI);
    check("addi_extop", {29'd0, extop}, 32'd0);
    cyc("addi_exec",  1'b1, BAD,  1'b0, 1'b0, 6'b000000);
    check("addi_bsrc", {31'd0, alu_bsrc}, 32'd1);
    cyc("addi_wb",    1'b1, BAD,  1'b0, 1'b0, 6'b000101);
    check("addi_wbsel", {30'd0, wb_sel}, 32'd0);
    check("addi_ir_hold", inst, ADDI);
    check("addi_no_trap", {31'd0, illegal}, 32'd0);
    $display("txn ADDI done");

    // LW with two dmem wait cycles: 7 cycles total
    cyc("lw_fetch", 1'b1, LW,  1'b0, 1'b0, 6'b100000);
    cyc("lw_dec",   1'b0, NOP, 1'b0, 1'b0, 6'b000000);
    check("lw_extop", {29'd0, extop}, 32'd0);
    cyc("lw_exec",  1'b0, NOP, 1'b0, 1'b0, 6'b000000);
    cyc("lw_mem0",  1'b0, NOP, 1'b0, 1'b0, 6'b010000);
    cyc("lw_mem1",  1'b0, NOP, 1'b0, 1'b0, 6'b010000);
    cyc("lw_mem2",  1'b0, NOP, 1'b1, 1'b0, 6'b010000);
    cyc("lw_wb",    1'b0, NOP, 1'b0, 1'b0, 6'b000101);
    check("lw_wbsel", {30'd0, wb_sel}, 32'd1);
    $display("txn LW done");

    // BEQ taken, then not taken: 3 cycles each
    cyc("beq1_fetch", 1'b1, BEQ, 1'b0, 1'b0, 6'b100000);
    cyc("beq1_dec",   1'b0, NOP, 1'b0, 1'b0, 6'b000000);
    check("beq_extop", {29'd0, extop}, 32'd3);
    check("beq_bsrc", {31'd0, alu_bsrc}, 32'd0);
    cyc("beq1_exec",  1'b0, NOP, 1'b0, 1'b1, 6'b000110);
    cyc("beq2_fetch", 1'b1, BEQ, 1'b0, 1'b0, 6'b100000);
    cyc("beq2_dec",   1'b0, NOP, 1'b0, 1'b0, 6'b000000);
    cyc("beq2_exec",  1'b0, NOP, 1'b0, 1'b0, 6'b000100);
    $display("txn BEQ x2 done");

    // JAL: write-back of PC+4 and jump target select
    cyc("jal_fetch", 1'b1, JAL, 1'b0, 1'b0, 6'b100000);
    cyc("jal_dec",   1'b0, NOP, 1'b0, 1'b0, 6'b000000);
    check("jal_extop", {29'd0, extop}, 32'd4);
    cyc("jal_exec",  1'b0, NOP, 1'b0, 1'b0, 6'b000000);
    cyc("jal_wb",    1'b0, NOP, 1'b0, 1'b0, 6'b000111);
    check("jal_wbsel", {30'd0, wb_sel}, 32'd2);
    $display("txn JAL done");

    // SW interrupted by reset mid-MEM
    cyc("sw_fetch", 1'b1, SW,  1'b0, 1'b0, 6'b100000);
    cyc("sw_dec",   1'b0, NOP, 1'b0, 1'b0, 6'b000000);
    check("sw_extop", {29'd0, extop}, 32'd2);
    cyc("sw_exec",  1'b0, NOP, 1'b0, 1'b0, 6'b000000);
    cyc("sw_mem",   1'b0, NOP, 1'b0, 1'b0, 6'b011000);
    #1 rst = 1'b1;
    #1;
    check("sw_rst_strobes", {26'd0, strobes}, 32'd0);
    check("sw_rst_ir", inst, NOP);
    @(posedge clk); #1 rst = 1'b0;
    cyc("rst_refetch", 1'b0, NOP, 1'b0, 1'b0, 6'b100000);
    check("rst_refetch_cycles", perf_cycles, 32'd0);
    $display("txn SW reset done");

    // Fresh reset, then 10 zero-wait ADDIs
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) run_addi(i);
    @(negedge clk); #1;
    check("perf_instret10", perf_instret, EXP_INSTRET);
    check("perf_cycles40", perf_cycles, EXP_CYC40);
    $display("txn 10xADDI done");

    // Illegal opcode traps for good; counters freeze
    imem_ready = 1'b1; imem_rdata = BAD; #1;
    check("bad_fetch", {26'd0, strobes}, 32'b100000);
    cyc("bad_dec", 1'b1, BAD, 1'b0, 1'b0, 6'b000000);
    check("bad_dec_illegal", {31'd0, illegal}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("trap%0d", i), 1'b1, ADDI, 1'b1, 1'b1, 6'b000000);
      check($sformatf("trap%0d_illegal", i), {31'd0, illegal}, 32'd1);
    end
    check("trap_instret", perf_instret, EXP_INSTRET);
    check("trap_cycles", perf_cycles, EXP_CYC42);
    $display("txn ILLEGAL done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
